// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release pulses, 8-bit press count.
// Optional auto-repeat while held is built only when KEY_REPEAT_EN is defined.
module key_debouncer #(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY,
  output logic       STABLE,
  output logic       PRESS,
  output logic       RELEASE,
  output logic [7:0] LED
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  // Counter value on the edge before acceptance; the accepting edge brings it to DB_CYCLES.
  localparam logic [23:0] DB_LAST = 24'(DB_CYCLES - 1);

  logic        r_k1;
  logic        r_k2;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_cnt;
  logic [23:0] w_cnt_nxt;
  logic [23:0] w_cnt_inc;
  logic        r_stable;
  logic        w_stable_nxt;
  logic        r_press;
  logic        w_press_nxt;
  logic        r_release;
  logic        w_release_nxt;
  logic [7:0]  r_led;
  logic [7:0]  w_led_nxt;

`ifdef KEY_REPEAT_EN
  localparam logic [24:0] REP_LAST = 25'(REPEAT_CYCLES - 1);

  logic [24:0] r_rep;
  logic [24:0] w_rep_nxt;
  logic        w_rep_hit;

  always_comb begin
    w_rep_nxt = 25'd0;
    w_rep_hit = 1'b0;
    if (r_state == ST_HIGH && r_k2) begin
      if (r_rep == REP_LAST) begin
        w_rep_hit = 1'b1;
      end else begin
        w_rep_nxt = r_rep + 25'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rep <= 25'd0;
    end else begin
      r_rep <= w_rep_nxt;
    end
  end
`else
  logic w_rep_hit;
  assign w_rep_hit = 1'b0;
`endif

  assign w_cnt_inc = (r_cnt == 24'hFF_FFFF) ? r_cnt : r_cnt + 24'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stable_nxt  = r_stable;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_led_nxt     = r_led;
    case (r_state)
      ST_LOW: begin
        w_stable_nxt = 1'b0;
        w_cnt_nxt    = 24'd0;
        if (r_k2) begin
          w_state_nxt = ST_WAIT_HIGH;
          w_cnt_nxt   = 24'd1;
        end
      end
      ST_WAIT_HIGH: begin
        if (!r_k2) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = 24'd0;
        end else if (r_cnt >= DB_LAST) begin
          w_state_nxt  = ST_HIGH;
          w_cnt_nxt    = w_cnt_inc;
          w_stable_nxt = 1'b1;
          w_press_nxt  = 1'b1;
          w_led_nxt    = r_led + 8'd1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HIGH: begin
        w_stable_nxt = 1'b1;
        w_cnt_nxt    = 24'd0;
        if (!r_k2) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = 24'd1;
        end else if (w_rep_hit) begin
          w_press_nxt = 1'b1;
          w_led_nxt   = r_led + 8'd1;
        end
      end
      ST_WAIT_LOW: begin
        if (r_k2) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = 24'd0;
        end else if (r_cnt >= DB_LAST) begin
          w_state_nxt   = ST_LOW;
          w_cnt_nxt     = w_cnt_inc;
          w_stable_nxt  = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = 24'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_k1      <= 1'b0;
      r_k2      <= 1'b0;
      r_state   <= ST_LOW;
      r_cnt     <= 24'd0;
      r_stable  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_led     <= 8'h00;
    end else begin
      r_k1      <= KEY;
      r_k2      <= r_k1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stable  <= w_stable_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_led     <= w_led_nxt;
    end
  end

  assign STABLE  = r_stable;
  assign PRESS   = r_press;
  assign RELEASE = r_release;
  assign LED     = r_led;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DB_CYCLES=4, REPEAT_CYCLES=10; expectations follow KEY_REPEAT_EN.
module tb_key_debouncer;

  logic       CLK;
  logic       RESET;
  logic       KEY;
  logic       STABLE;
  logic       PRESS;
  logic       RELEASE;
  logic [7:0] LED;

  int n_chk;
  int n_pass;
  int n_press;
  int n_rel;
  int n_overlap;
  logic [7:0] exp_led;

  key_debouncer #(.DB_CYCLES(4), .REPEAT_CYCLES(10)) dut (
    .CLK(CLK), .RESET(RESET), .KEY(KEY),
    .STABLE(STABLE), .PRESS(PRESS), .RELEASE(RELEASE), .LED(LED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (PRESS === 1'b1) n_press++;
    if (RELEASE === 1'b1) n_rel++;
    if (PRESS === 1'b1 && RELEASE === 1'b1) n_overlap++;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    KEY = 1'b0;
    repeat (2) step();
    n_chk++;
    if ({STABLE, PRESS, RELEASE, LED} !== 11'd0)
      $display("FAIL reset_outputs: got %b, want 0", {STABLE, PRESS, RELEASE, LED});
    else n_pass++;
    RESET = 1'b0;
    repeat (3) step();
    n_chk++;
    if ({STABLE, PRESS, RELEASE, LED} !== 11'd0)
      $display("FAIL idle_after_reset: got %b, want 0", {STABLE, PRESS, RELEASE, LED});
    else n_pass++;
    exp_led = 8'd0;
  endtask

  task automatic test_clean_press();
    int early;
    early = 0;
    n_press = 0;
    KEY = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (PRESS !== 1'b0 || STABLE !== 1'b0) early++;
    end
    n_chk++;
    if (early != 0) $display("FAIL press_early: got %0d early cycles, want 0", early);
    else n_pass++;
    step();
    exp_led = exp_led + 8'd1;
    n_chk++;
    if (PRESS !== 1'b1 || STABLE !== 1'b1 || LED !== exp_led)
      $display("FAIL press_edge6: got press=%b stable=%b led=%0d, want 1 1 %0d", PRESS, STABLE, LED, exp_led);
    else n_pass++;
    step();
    n_chk++;
    if (PRESS !== 1'b0) $display("FAIL press_width: got %b, want 0", PRESS);
    else n_pass++;
    repeat (13) step();
`ifdef KEY_REPEAT_EN
    exp_led = exp_led + 8'd1;
`endif
    KEY = 1'b0;
    early = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (RELEASE !== 1'b0 || STABLE !== 1'b1) early++;
    end
    n_chk++;
    if (early != 0) $display("FAIL release_early: got %0d early cycles, want 0", early);
    else n_pass++;
    step();
    n_chk++;
    if (RELEASE !== 1'b1 || STABLE !== 1'b0 || LED !== exp_led)
      $display("FAIL release_edge6: got rel=%b stable=%b led=%0d, want 1 0 %0d", RELEASE, STABLE, LED, exp_led);
    else n_pass++;
    step();
    n_chk++;
    if (RELEASE !== 1'b0) $display("FAIL release_width: got %b, want 0", RELEASE);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      KEY = ((i / 2) % 2 == 0);
      step();
      if (PRESS !== 1'b0 || RELEASE !== 1'b0 || STABLE !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL bounce_quiet: got %0d active cycles, want 0", bad);
    else n_pass++;
    KEY = 1'b1;
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (PRESS !== 1'b0) bad++;
    end
    step();
    exp_led = exp_led + 8'd1;
    n_chk++;
    if (bad != 0 || PRESS !== 1'b1 || LED !== exp_led)
      $display("FAIL bounce_press: got early=%0d press=%b led=%0d, want 0 1 %0d", bad, PRESS, LED, exp_led);
    else n_pass++;
    KEY = 1'b0;
    repeat (8) step();
    n_chk++;
    if (STABLE !== 1'b0) $display("FAIL bounce_release: got stable=%b, want 0", STABLE);
    else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    KEY = 1'b1;
    repeat (3) step();
    RESET = 1'b1;
    #1;
    n_chk++;
    if ({STABLE, PRESS, RELEASE, LED} !== 11'd0)
      $display("FAIL mid_reset_outputs: got %b, want 0", {STABLE, PRESS, RELEASE, LED});
    else n_pass++;
    repeat (2) step();
    RESET = 1'b0;
    n_press = 0;
    repeat (5) step();
    n_chk++;
    if (n_press != 0) $display("FAIL mid_reset_early: got %0d presses, want 0", n_press);
    else n_pass++;
    step();
    n_chk++;
    if (PRESS !== 1'b1 || LED !== 8'd1 || STABLE !== 1'b1)
      $display("FAIL mid_reset_press: got press=%b led=%0d stable=%b, want 1 1 1", PRESS, LED, STABLE);
    else n_pass++;
  endtask

  task automatic test_reset_in_high();
    step();
    RESET = 1'b1;
    #1;
    n_chk++;
    if ({STABLE, PRESS, RELEASE, LED} !== 11'd0)
      $display("FAIL high_reset_outputs: got %b, want 0", {STABLE, PRESS, RELEASE, LED});
    else n_pass++;
    KEY = 1'b0;
    repeat (2) step();
    RESET = 1'b0;
    n_rel = 0;
    n_press = 0;
    repeat (10) step();
    n_chk++;
    if (n_rel != 0 || n_press != 0 || STABLE !== 1'b0 || LED !== 8'd0)
      $display("FAIL high_reset_quiet: got rel=%0d press=%0d stable=%b led=%0d, want 0 0 0 0", n_rel, n_press, STABLE, LED);
    else n_pass++;
  endtask

  task automatic test_wrap();
    n_press = 0;
    for (int p = 1; p <= 256; p++) begin
      KEY = 1'b1;
      repeat (6) step();
      KEY = 1'b0;
      repeat (8) step();
      if (p == 255) begin
        n_chk++;
        if (LED !== 8'd255) $display("FAIL wrap_255: got %0d, want 255", LED);
        else n_pass++;
      end
    end
    n_chk++;
    if (LED !== 8'd0) $display("FAIL wrap_256: got %0d, want 0", LED);
    else n_pass++;
    n_chk++;
    if (n_press != 256) $display("FAIL wrap_count: got %0d presses, want 256", n_press);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int bad;
    logic exp_p;
    RESET = 1'b1;
    repeat (2) step();
    RESET = 1'b0;
    KEY = 1'b1;
    repeat (6) step();
    n_chk++;
    if (PRESS !== 1'b1 || LED !== 8'd1)
      $display("FAIL repeat_initial: got press=%b led=%0d, want 1 1", PRESS, LED);
    else n_pass++;
    bad = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
`ifdef KEY_REPEAT_EN
      exp_p = (i % 10 == 0);
`else
      exp_p = 1'b0;
`endif
      if (PRESS !== exp_p) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL repeat_timing: got %0d wrong cycles, want 0", bad);
    else n_pass++;
    KEY = 1'b0;
    n_rel = 0;
    n_press = 0;
    repeat (10) step();
`ifdef KEY_REPEAT_EN
    exp_led = 8'd5;
`else
    exp_led = 8'd1;
`endif
    n_chk++;
    if (LED !== exp_led || n_rel != 1 || n_press != 0 || STABLE !== 1'b0)
      $display("FAIL repeat_end: got led=%0d rel=%0d press=%0d stable=%b, want %0d 1 0 0", LED, n_rel, n_press, STABLE, exp_led);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_press = 0;
    n_rel = 0;
    n_overlap = 0;
    exp_led = 8'd0;
    RESET = 1'b1;
    KEY = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_reset_mid_debounce();
    test_reset_in_high();
    test_wrap();
    test_repeat();
    n_chk++;
    if (n_overlap != 0) $display("FAIL press_release_overlap: got %0d cycles, want 0", n_overlap);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Input-side companion to the LED divider display: conditions one mechanical push-button into a clean, debounced level. It emits single-cycle press and release pulses and keeps an 8-bit press count for the LED bank. It sits between the board's KEY pin and any logic or display that consumes user input.

## Interface

Parameters:
- DB_CYCLES, 1_000_000: consecutive cycles the synchronized key must hold a new level before it is accepted (20 ms at 50 MHz); legal range 2..2^24-1.
- REPEAT_CYCLES, 25_000_000: auto-repeat interval while held. Used only with KEY_REPEAT_EN.

Ports:
- CLK, input, 1: system clock; all logic on the rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- KEY, input, 1: raw button; asynchronous, bouncy; 1 = pressed.
- STABLE, output, 1: debounced key level.
- PRESS, output, 1: one-cycle pulse on an accepted press (and on repeats).
- RELEASE, output, 1: one-cycle pulse on an accepted release.
- LED, output, 8: press count; wraps 255 -> 0.

All outputs are registered.

## Operation

- KEY passes through a 2-flop synchronizer (k1 -> k2). Only k2 is used downstream.
- FSM states:
  - LOW: STABLE=0, counter=0. If k2=1, go to WAIT_HIGH with counter=1.
  - WAIT_HIGH: if k2=0, go back to LOW and clear the counter. Otherwise increment the counter. On the edge where the counter reaches DB_CYCLES, go to HIGH, set STABLE=1, pulse PRESS, increment LED.
  - HIGH: STABLE=1. If k2=0, go to WAIT_LOW with counter=1.
  - WAIT_LOW: the mirror of WAIT_HIGH. It returns to HIGH on k2=1. On acceptance it goes to LOW, sets STABLE=0 and pulses RELEASE. LED is unchanged.
- Any bounce inside a WAIT state aborts back to the prior stable state with no pulse. The counter restarts from 1 on the next deviation.
- Debounce counter width is 24 bits. It saturates and never wraps.
- LED arithmetic is modulo 256.
- PRESS and RELEASE are never high in the same cycle. PRESS only occurs on entry to HIGH (or on a repeat in HIGH); RELEASE only on entry to LOW.

## Timing

- Reset values: STABLE=0, PRESS=0, RELEASE=0, LED=8'h00, k1=k2=0, FSM=LOW, all counters 0.
- Latency: KEY is sampled high at edge 0 and held. k2=1 after edge 1. PRESS is high in the cycle following edge DB_CYCLES+1 (DB_CYCLES+2 edges total). STABLE and LED update on that same edge. Release latency is identical.
- A pulse lasts exactly one clock.
- A glitch shorter than DB_CYCLES synchronized cycles produces no output change.
- Reset mid-operation: all state clears immediately, including during a WAIT state. If KEY is still held after reset deasserts, it is debounced from LOW as a fresh press, and PRESS fires.

## Configuration

- KEY_REPEAT_EN defined:
  - In HIGH, a 25-bit repeat counter counts cycles.
  - When it reaches REPEAT_CYCLES, PRESS pulses, LED increments, and the counter restarts at 0.
  - The counter clears on leaving HIGH and on reset.
  - First repeat: REPEAT_CYCLES cycles after the initial PRESS.
- KEY_REPEAT_EN undefined:
  - No repeat counter is built.
  - A held key yields exactly one PRESS.
  - REPEAT_CYCLES is ignored.

## Test plan

All scenarios use DB_CYCLES=4 and REPEAT_CYCLES=10.

- Clean press: KEY 0->1 held 20 cycles, then 1->0. Required: PRESS high for one cycle 6 edges after the rise, STABLE=1, LED=1. RELEASE high for one cycle 6 edges after the fall, STABLE=0, LED=1.
- Bounce rejection: KEY toggles every 2 cycles for 16 cycles, then holds 1. Required: no pulse during the bounce; a single PRESS 6 edges after the final rise; LED=1.
- Wrap: 256 clean presses. Required: LED reads 255 after press 255 and 0 after press 256; the PRESS count equals 256.
- Reset mid-debounce: assert RESET in WAIT_HIGH with KEY held, then release it. Required: all outputs are 0 during reset; PRESS fires 6 edges after reset deasserts; LED=1.
- Reset in HIGH: assert RESET with STABLE=1. Required: STABLE, LED, PRESS and RELEASE are all 0 immediately (asynchronous), with no RELEASE pulse.
- KEY_REPEAT_EN: hold KEY for 40 cycles after acceptance. Required: the initial PRESS plus repeats at +10, +20, +30 and +40 cycles; LED=5; a single RELEASE after the key is let go. With the macro undefined, the same stimulus gives LED=1.
